seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display bank, used by the clock top level to show time fields. Scans one digit per slot, decodes its 4-bit nibble (0-9, optionally A-F), and applies per-digit decimal point, blanking and blink. Replaces per-digit static decoders with one shared decoder and registered anode/segment outputs.

Parameters:
NUM_DIGITS, 6, number of digits scanned (1..16)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
HEX_EN, 1, 1: nibbles 10-15 show A,b,C,d,E,F; 0: nibbles 10-15 show blank

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  1: scanning and display active; 0: display dark, counters frozen
digits_in  input  4*NUM_DIGITS  nibble k at [4k+3:4k], digit 0 rightmost
dp_in  input  NUM_DIGITS  bit k lights decimal point of digit k
blank_in  input  NUM_DIGITS  bit k forces digit k dark
blink_in  input  NUM_DIGITS  bit k makes digit k blink
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_out  output  1  decimal point, active-low
an_out  output  NUM_DIGITS  anode select, active-low, at most one bit low
blink_phase  output  1  current blink phase, 1 = blinking digits dark

Behaviour:
- Reset (rst=1 at clk edge): scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0, seg_out=7'h7F, dp_out=1, an_out=all ones. Reset wins over every other input.
- scan_cnt: width clog2(SCAN_DIV); counts 0..SCAN_DIV-1 while en=1. At SCAN_DIV-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- blink_cnt: counts 0..BLINK_DIV-1 while en=1. At the terminal count it wraps to 0 and blink_phase toggles.
- en=0: all counters and idx hold; the registered outputs go dark next cycle (seg 7'h7F, dp 1, an all ones). When en returns to 1, scanning resumes from the held state.
- Outputs are registered, with 1-cycle latency from idx/inputs to pins. Inputs are sampled every cycle, so a digit change becomes visible within its current slot.
- Dead time: in the registered cycle corresponding to scan_cnt==0, an_out is all ones (anti-ghosting). seg_out and dp_out already carry the new digit's values.
- Digit k is dark if blank_in[k]=1, or if blink_in[k]=1 and blink_phase=1. A dark digit drives an_out all ones, seg 7'h7F and dp 1, and still consumes its full slot, so brightness stays uniform.
- Otherwise: an_out[idx]=0 and all other bits 1; dp_out=~dp_in[idx].
- seg_out decode:
  - 0..9 use the team codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - With HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - With HEX_EN=0, 10-15 give 1111111.
- Simultaneous scan and blink wraps on the same cycle are independent: both take effect.
- NUM_DIGITS=1: idx is held at 0, and dead time still applies once per slot.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_0..SEG_F and SEG_BLANK (7'h7F) constants
  - the segment bit-order definition
  - the function/constant for clog2 counter widths
- One sub-module, seg7_hex_decode: combinational, 4-bit in to 7-bit active-low out, parameter HEX_EN. It is instantiated once on the muxed nibble.

Test Plan:
- Reset: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16; hold rst 3 cycles -> seg_out=7F, dp_out=1, an_out=1111, blink_phase=0; release -> first non-dead cycle shows an_out=1110.
- Scan order: digits_in=16'h3210 -> the non-dead cycle of each slot shows an_out 1110/1101/1011/0111 with seg 1000000/1111001/0100100/0110000. Each slot is 4 cycles with 1 dead cycle; idx wraps to digit 0 after digit 3.
- Hex/blank decode: nibble B with HEX_EN=1 -> seg 0000011; same nibble with HEX_EN=0 -> 1111111. blank_in=0100 -> an_out stays 1111 during slot 2; slot length is unchanged.
- Blink: blink_in=0001 -> digit 0 is lit for 16 cycles, dark for 16 cycles, and so on; blink_phase toggles every 16 cycles; other digits are unaffected.
- Decimal point / en: dp_in=0010 -> dp_out=0 only in slot 1. Deassert en mid-slot -> next cycle outputs are dark; reassert -> scan_cnt and idx resume from held values.
- Reset mid-operation: assert rst with idx=2 and blink_phase=1 -> next cycle all outputs and counters return to reset values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a} (bit 0 = a).
package seg7_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Width of a counter/index covering 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-bank bundle: digit data and controls in, scanned anode/segment pins out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 6
);

  logic                      en;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic [NUM_DIGITS-1:0]     blink_in;
  logic [6:0]                seg_out;
  logic                      dp_out;
  logic [NUM_DIGITS-1:0]     an_out;
  logic                      blink_phase;

  modport master (
    output en, digits_in, dp_in, blank_in, blink_in,
    input  seg_out, dp_out, an_out, blink_phase
  );

  modport slave (
    input  en, digits_in, dp_in, blank_in, blink_in,
    output seg_out, dp_out, an_out, blink_phase
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment decoder; 10-15 show A-F or blank depending on HEX_EN.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = HEX_EN ? SEG_A : SEG_BLANK;
      4'hB: seg = HEX_EN ? SEG_B : SEG_BLANK;
      4'hC: seg = HEX_EN ? SEG_C : SEG_BLANK;
      4'hD: seg = HEX_EN ? SEG_D : SEG_BLANK;
      4'hE: seg = HEX_EN ? SEG_E : SEG_BLANK;
      4'hF: seg = HEX_EN ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one shared decoder, registered pins
// (1-cycle latency), anti-ghost dead cycle at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int BW = cnt_width(BLINK_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);

  logic [SW-1:0]          scan_cnt, scan_cnt_nxt;
  logic [BW-1:0]          blink_cnt, blink_cnt_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic                   phase, phase_nxt;

  logic [6:0]             seg_q, seg_nxt;
  logic                   dp_q, dp_nxt;
  logic [NUM_DIGITS-1:0]  an_q, an_nxt;

  logic [3:0]             nib_arr [NUM_DIGITS];
  logic [3:0]             nibble;
  logic [6:0]             dec_seg;
  logic                   dark;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
    assign nib_arr[k] = bus.digits_in[4*k +: 4];
  end

  seg7_hex_decode #(.HEX_EN(HEX_EN)) u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    nibble = nib_arr[idx];
    dark   = bus.blank_in[idx] | (bus.blink_in[idx] & phase);

    seg_nxt = dark ? SEG_BLANK : dec_seg;
    dp_nxt  = dark | ~bus.dp_in[idx];
    an_nxt  = '1;
    // First cycle of every slot keeps all anodes off so the previous digit cannot ghost.
    if (!dark && scan_cnt != '0) begin
      an_nxt = ~(NUM_DIGITS'(1) << idx);
    end

    scan_cnt_nxt = scan_cnt + SW'(1);
    idx_nxt      = idx;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt_nxt = '0;
      idx_nxt      = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    blink_cnt_nxt = blink_cnt + BW'(1);
    phase_nxt     = phase;
    if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else if (bus.en) begin
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      seg_q     <= seg_nxt;
      dp_q      <= dp_nxt;
      an_q      <= an_nxt;
    end else begin
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.an_out      = an_q;
  assign bus.blink_phase = phase;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench: a reference model pushes expected pin values each clock, a monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus  ();
  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus2 ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .HEX_EN(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .HEX_EN(1'b0)) dut_nohex (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  assign bus2.en        = bus.en;
  assign bus2.digits_in = bus.digits_in;
  assign bus2.dp_in     = bus.dp_in;
  assign bus2.blank_in  = bus.blank_in;
  assign bus2.blink_in  = bus.blink_in;

  typedef struct packed {
    logic [6:0]    seg;
    logic [6:0]    seg_nh;
    logic          dp;
    logic [ND-1:0] an;
    logic          bp;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return hex ? 7'b0001000 : 7'b1111111;
      4'hB: return hex ? 7'b0000011 : 7'b1111111;
      4'hC: return hex ? 7'b1000110 : 7'b1111111;
      4'hD: return hex ? 7'b0100001 : 7'b1111111;
      4'hE: return hex ? 7'b0000110 : 7'b1111111;
      default: return hex ? 7'b0001110 : 7'b1111111;
    endcase
  endfunction

  // Reference model state.
  int   m_scan = 0, m_idx = 0, m_bc = 0;
  logic m_bp = 1'b0;
  exp_t e_new;
  logic [3:0] m_nib;
  logic       m_dark;

  always @(posedge clk) begin
    if (rst) begin
      m_scan = 0; m_idx = 0; m_bc = 0; m_bp = 1'b0;
      e_new = '{seg: 7'h7F, seg_nh: 7'h7F, dp: 1'b1, an: '1, bp: 1'b0};
    end else if (!bus.en) begin
      e_new = '{seg: 7'h7F, seg_nh: 7'h7F, dp: 1'b1, an: '1, bp: m_bp};
    end else begin
      m_nib  = bus.digits_in[m_idx*4 +: 4];
      m_dark = bus.blank_in[m_idx] | (bus.blink_in[m_idx] & m_bp);
      e_new.seg    = m_dark ? 7'h7F : ref_seg(m_nib, 1'b1);
      e_new.seg_nh = m_dark ? 7'h7F : ref_seg(m_nib, 1'b0);
      e_new.dp     = m_dark ? 1'b1 : ~bus.dp_in[m_idx];
      e_new.an     = '1;
      if (!m_dark && m_scan != 0) e_new.an[m_idx] = 1'b0;
      if (m_scan == SD - 1) begin m_scan = 0; m_idx = (m_idx + 1) % ND; end
      else m_scan++;
      if (m_bc == BD - 1) begin m_bc = 0; m_bp = ~m_bp; end
      else m_bc++;
      e_new.bp = m_bp;
    end
    q.push_back(e_new);
  end

  exp_t e_mon;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("pins_hex", 32'({bus.seg_out, bus.dp_out, bus.an_out, bus.blink_phase}),
                      32'({e_mon.seg, e_mon.dp, e_mon.an, e_mon.bp}));
      chk("pins_nohex", 32'({bus2.seg_out, bus2.dp_out, bus2.an_out, bus2.blink_phase}),
                        32'({e_mon.seg_nh, e_mon.dp, e_mon.an, e_mon.bp}));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] vecs [4];
  int wait_n;

  initial begin
    vecs[0] = 16'h3210; vecs[1] = 16'h7654; vecs[2] = 16'hBA98; vecs[3] = 16'hFEDC;
    bus.en = 1'b1; bus.digits_in = 16'h3210;
    bus.dp_in = '0; bus.blank_in = '0; bus.blink_in = '0;

    run(3);
    chk("rst_seg", 32'(bus.seg_out), 32'h7F);
    chk("rst_dp", 32'(bus.dp_out), 32'h1);
    chk("rst_an", 32'(bus.an_out), 32'hF);
    chk("rst_bp", 32'(bus.blink_phase), 32'h0);
    rst = 1'b0;
    run(1);
    chk("first_dead_an", 32'(bus.an_out), 32'hF);
    chk("first_dead_seg", 32'(bus.seg_out), 32'h40);
    run(1);
    chk("first_lit_an", 32'(bus.an_out), 32'hE);
    run(1);
    chk("slot0_seg_2nd", 32'(bus.seg_out), 32'h40);
    run(13);

    for (int v = 0; v < 4; v++) begin
      bus.digits_in = vecs[v];
      run(16);
    end

    bus.digits_in = 16'h3B10;
    bus.blank_in  = 4'b0100;
    run(20);
    bus.blank_in  = '0;

    bus.blink_in = 4'b0001;
    run(48);
    bus.blink_in = '0;

    bus.dp_in = 4'b0010;
    run(18);
    bus.en = 1'b0;
    run(5);
    chk("en0_an", 32'(bus.an_out), 32'hF);
    chk("en0_seg", 32'(bus.seg_out), 32'h7F);
    bus.en = 1'b1;
    run(14);
    bus.dp_in = '0;

    bus.blink_in = 4'b0100;
    wait_n = 0;
    while (!(m_idx == 2 && m_bp == 1'b1) && wait_n < 400) begin
      run(1);
      wait_n++;
    end
    chk("reach_idx2_phase1", 32'(wait_n < 400), 32'h1);
    chk("bp_before_rst", 32'(bus.blink_phase), 32'h1);
    rst = 1'b1;
    run(1);
    chk("midrst_an", 32'(bus.an_out), 32'hF);
    chk("midrst_seg", 32'(bus.seg_out), 32'h7F);
    chk("midrst_bp", 32'(bus.blink_phase), 32'h0);
    rst = 1'b0;
    run(12);

    run(1);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
